// File: rtl/versat_addrgen_pkg.sv
// Shared definitions for the Versat address generators: state encoding and
// the byte-offset width derived from the element size.
package versat_addrgen_pkg;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] DELAY = 2'd1;
    localparam logic [1:0] RUN   = 2'd2;
    localparam logic [1:0] DONE  = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE  = IDLE,
        ST_DELAY = DELAY,
        ST_RUN   = RUN,
        ST_DONE  = DONE
    } state_t;

    // Number of address bits covered by one element (log2 of bytes per element).
    function automatic int offset_w(input int data_w);
        return $clog2(data_w / 32'sd8);
    endfunction

endpackage

// File: rtl/multi_loop_address_gen_if.sv
// Configuration and address handshake bundle between a Versat unit and its
// nested-loop address generator.
interface multi_loop_address_gen_if #(
    parameter int ADDR_W   = 10,
    parameter int PERIOD_W = 10,
    parameter int ITER_W   = 10,
    parameter int DELAY_W  = 32
);
    logic                       run;
    logic [PERIOD_W-1:0]        period;
    logic [ITER_W-1:0]          iterations;
    logic [DELAY_W-1:0]         delay;
    logic [ADDR_W-1:0]          start;
    logic signed [ADDR_W-1:0]   incr;
    logic signed [ADDR_W-1:0]   shift;
    logic                       valid;
    logic                       ready;
    logic [ADDR_W-1:0]          addr;
    logic                       last;
    logic                       done;

    modport master (
        input  run, period, iterations, delay, start, incr, shift, ready,
        output valid, addr, last, done
    );

    modport slave (
        output run, period, iterations, delay, start, incr, shift, ready,
        input  valid, addr, last, done
    );
endinterface

// File: rtl/multi_loop_address_gen_loop_counter.sv
// Single loop level: counts enabled steps up to limit-1 and wraps to zero,
// reporting whether the current and the upcoming count are the terminal one.
module loop_counter #(
    parameter int W = 10
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         en,
    input  logic [W-1:0] limit,
    output logic         terminal,
    output logic         terminal_nxt
);
    logic [W-1:0] count_r;
    logic [W-1:0] count_nxt_s;

    // Next count: clear wins, otherwise step with wrap at the terminal count.
    always_comb begin
        count_nxt_s = count_r;
        if (clr) begin
            count_nxt_s = '0;
        end else if (en) begin
            if (terminal) begin
                count_nxt_s = '0;
            end else begin
                count_nxt_s = count_r + {{(W-1){1'b0}}, 1'b1};
            end
        end else begin
            count_nxt_s = count_r;
        end
    end

    // Compared one bit wider so a full-scale limit cannot alias through overflow.
    assign terminal     = ({1'b0, count_r} + {{W{1'b0}}, 1'b1}) == {1'b0, limit};
    assign terminal_nxt = ({1'b0, count_nxt_s} + {{W{1'b0}}, 1'b1}) == {1'b0, limit};

    // Count register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_r <= '0;
        end else begin
            count_r <= count_nxt_s;
        end
    end
endmodule

// File: rtl/multi_loop_address_gen.sv
// Two-level nested-loop byte address generator with start delay, last flag
// and restart on run; loop counts and steps are in element units.
module multi_loop_address_gen
    import versat_addrgen_pkg::*;
#(
    parameter int ADDR_W   = 10,
    parameter int PERIOD_W = 10,
    parameter int ITER_W   = 10,
    parameter int DELAY_W  = 32,
    parameter int DATA_W   = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    multi_loop_address_gen_if.master bus
);
    localparam int OFFSET_W = offset_w(DATA_W);
    localparam logic [DELAY_W-1:0]  DLY_ONE = {{(DELAY_W-1){1'b0}}, 1'b1};
    localparam logic [PERIOD_W-1:0] PER_ONE = {{(PERIOD_W-1){1'b0}}, 1'b1};
    localparam logic [ITER_W-1:0]   ITR_ONE = {{(ITER_W-1){1'b0}}, 1'b1};

    state_t                   state_r;
    logic                     valid_r;
    logic                     last_r;
    logic                     done_r;
    logic [ADDR_W-1:0]        addr_r;
    logic [DELAY_W-1:0]       dcnt_r;
    logic [PERIOD_W-1:0]      period_r;
    logic [ITER_W-1:0]        iter_r;
    logic signed [ADDR_W-1:0] incr_r;
    logic signed [ADDR_W-1:0] shift_r;

    logic signed [ADDR_W-1:0] step_s;
    logic signed [ADDR_W-1:0] wrap_s;
    logic                     xfer_s;
    logic                     in_term_s;
    logic                     in_term_nxt_s;
    logic                     out_term_s;
    logic                     out_term_nxt_s;
    logic                     last_nxt_s;

    // A run in the same cycle restarts the sequence, so it never counts as a step.
    assign xfer_s     = (state_r == ST_RUN) && valid_r && bus.ready && !bus.run;
    assign last_nxt_s = in_term_nxt_s && out_term_nxt_s;

    loop_counter #(.W(PERIOD_W)) u_inner (
        .clk          (clk),
        .rst          (rst),
        .clr          (bus.run),
        .en           (xfer_s),
        .limit        (period_r),
        .terminal     (in_term_s),
        .terminal_nxt (in_term_nxt_s)
    );

    loop_counter #(.W(ITER_W)) u_outer (
        .clk          (clk),
        .rst          (rst),
        .clr          (bus.run),
        .en           (xfer_s && in_term_s),
        .limit        (iter_r),
        .terminal     (out_term_s),
        .terminal_nxt (out_term_nxt_s)
    );

    // Element steps scaled to bytes; sums wrap modulo 2^ADDR_W.
    always_comb begin
        step_s = incr_r <<< OFFSET_W;
        wrap_s = (incr_r + shift_r) <<< OFFSET_W;
    end

    // Sequencer: configuration capture, start delay, address stepping, completion.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r  <= ST_IDLE;
            valid_r  <= 1'b0;
            last_r   <= 1'b0;
            done_r   <= 1'b0;
            addr_r   <= '0;
            dcnt_r   <= '0;
            period_r <= '0;
            iter_r   <= '0;
            incr_r   <= '0;
            shift_r  <= '0;
        end else if (bus.run) begin
            addr_r   <= bus.start;
            period_r <= bus.period;
            iter_r   <= bus.iterations;
            incr_r   <= bus.incr;
            shift_r  <= bus.shift;
            last_r   <= 1'b0;
            done_r   <= 1'b0;
            if ((bus.period == '0) || (bus.iterations == '0)) begin
                state_r <= ST_DONE;
                valid_r <= 1'b0;
                done_r  <= 1'b1;
            end else if (bus.delay == '0) begin
                state_r <= ST_RUN;
                valid_r <= 1'b1;
                last_r  <= (bus.period == PER_ONE) && (bus.iterations == ITR_ONE);
            end else begin
                state_r <= ST_DELAY;
                valid_r <= 1'b0;
                dcnt_r  <= bus.delay - DLY_ONE;
            end
        end else begin
            case (state_r)
                ST_IDLE: begin
                    valid_r <= 1'b0;
                end
                ST_DELAY: begin
                    if (dcnt_r == '0) begin
                        state_r <= ST_RUN;
                        valid_r <= 1'b1;
                        last_r  <= last_nxt_s;
                    end else begin
                        dcnt_r <= dcnt_r - DLY_ONE;
                    end
                end
                ST_RUN: begin
                    if (xfer_s) begin
                        if (in_term_s && out_term_s) begin
                            state_r <= ST_DONE;
                            valid_r <= 1'b0;
                            done_r  <= 1'b1;
                            last_r  <= 1'b0;
                        end else begin
                            addr_r <= addr_r + (in_term_s ? wrap_s : step_s);
                            last_r <= last_nxt_s;
                        end
                    end
                end
                ST_DONE: begin
                    valid_r <= 1'b0;
                    done_r  <= 1'b1;
                end
                default: begin
                    state_r <= ST_IDLE;
                    valid_r <= 1'b0;
                    last_r  <= 1'b0;
                    done_r  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.valid = valid_r;
    assign bus.addr  = addr_r;
    assign bus.last  = last_r;
    assign bus.done  = done_r;
endmodule

// File: tb/tb_multi_loop_address_gen.sv
// Randomized scoreboard bench for multi_loop_address_gen; expected addresses
// come from the closed-form position formula of the nested loops.
module tb_multi_loop_address_gen;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    multi_loop_address_gen_if #(.ADDR_W(10), .PERIOD_W(10), .ITER_W(10), .DELAY_W(32)) bi ();
    multi_loop_address_gen_if #(.ADDR_W(4), .PERIOD_W(4), .ITER_W(4), .DELAY_W(8)) bs ();

    multi_loop_address_gen #(.ADDR_W(10), .PERIOD_W(10), .ITER_W(10), .DELAY_W(32), .DATA_W(32)) dut (
        .clk (clk), .rst (rst), .bus (bi.master)
    );
    multi_loop_address_gen #(.ADDR_W(4), .PERIOD_W(4), .ITER_W(4), .DELAY_W(8), .DATA_W(8)) dut_s (
        .clk (clk), .rst (rst), .bus (bs.master)
    );

    typedef struct {
        int   addr;
        logic last;
    } exp_t;

    exp_t exp_q[$];
    exp_t me;
    int   total = 0;
    int   bad = 0;
    int   xfers = 0;
    int   ready_mode = 0;
    int   final_addr = 0;
    logic prev_hold = 1'b0;
    logic [9:0] prev_addr;

    function automatic int sext(input int v, input int w);
        if (((v >> (w - 1)) & 1) == 1) return v - (1 << w);
        return v;
    endfunction

    // Address of element p in pass it: every element advances by incr, every pass adds shift.
    function automatic int model_addr(input int aw, input int es, input int st, input int inc,
                                      input int sh, input int per, input int p, input int it);
        longint a;
        a = longint'(st) + ((longint'(it) * per + p) * inc + longint'(it) * sh) * es;
        return int'(a & ((64'sd1 <<< aw) - 64'sd1));
    endfunction

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Ready driver
    initial begin
        int rpat = 0;
        bi.ready = 1'b1;
        forever begin
            @(posedge clk); #1;
            case (ready_mode)
                0: bi.ready = 1'b1;
                1: bi.ready = ($urandom_range(0, 1) == 1);
                default: begin
                    bi.ready = (rpat % 3 == 0);
                    rpat++;
                end
            endcase
        end
    end

    // Monitor: pops the scoreboard on every accepted address
    initial begin
        forever begin
            @(negedge clk);
            if (!rst && bi.valid && !bi.run) begin
                if (prev_hold) check("addr_hold", int'(bi.addr), int'(prev_addr));
                if (bi.ready) begin
                    xfers++;
                    if (exp_q.size() == 0) begin
                        check("extra_transfer", int'(bi.addr), -1);
                    end else begin
                        me = exp_q.pop_front();
                        check("addr", int'(bi.addr), me.addr);
                        check("last", int'(bi.last), int'(me.last));
                    end
                end
                prev_hold = !bi.ready;
                prev_addr = bi.addr;
            end else begin
                prev_hold = 1'b0;
            end
        end
    end

    task automatic issue_run(input int per, input int it, input int dly, input int st,
                             input int inc, input int sh);
        exp_t e;
        exp_q.delete();
        for (int i = 0; i < it; i++) begin
            for (int p = 0; p < per; p++) begin
                e.addr = model_addr(10, 4, st, sext(inc, 10), sext(sh, 10), per, p, i);
                e.last = (p == per - 1) && (i == it - 1);
                exp_q.push_back(e);
            end
        end
        final_addr = (per * it > 0) ? model_addr(10, 4, st, sext(inc, 10), sext(sh, 10), per, per - 1, it - 1) : st;
        bi.run = 1'b1;
        bi.period = 10'(per);
        bi.iterations = 10'(it);
        bi.delay = 32'(dly);
        bi.start = 10'(st);
        bi.incr = 10'(inc);
        bi.shift = 10'(sh);
        @(posedge clk); #1;
        xfers = 0;
        bi.run = 1'b0;
        bi.period = 10'($urandom);
        bi.iterations = 10'($urandom);
        bi.delay = $urandom;
        bi.start = 10'($urandom);
        bi.incr = 10'($urandom);
        bi.shift = 10'($urandom);
    endtask

    task automatic wait_done(input int per, input int it, input int dly);
        int n = 0;
        int pi = per * it;
        logic saw = 1'b0;
        while (1) begin
            if (pi > 0 && dly > 0 && n == dly - 1) check("pre_valid", int'(bi.valid), 0);
            if (pi > 0 && n == dly) check("first_valid", int'(bi.valid), 1);
            if (bi.valid) saw = 1'b1;
            if (bi.done) break;
            if (n >= 3000) begin
                check("done_timeout", n, -1);
                break;
            end
            @(posedge clk); #1;
            n++;
        end
        check("done", int'(bi.done), 1);
        check("valid_at_done", int'(bi.valid), 0);
        check("last_at_done", int'(bi.last), 0);
        check("done_addr", int'(bi.addr), final_addr);
        check("xfer_count", xfers, pi);
        check("queue_empty", exp_q.size(), 0);
        if (ready_mode == 0) check("done_cycle", n, (pi == 0) ? 0 : dly + pi);
        if (pi == 0) check("no_valid", int'(saw), 0);
    endtask

    task automatic seq(input int per, input int it, input int dly, input int st,
                       input int inc, input int sh);
        issue_run(per, it, dly, st, inc, sh);
        wait_done(per, it, dly);
    endtask

    initial begin
        rst = 1'b1;
        bi.run = 1'b0; bi.period = '0; bi.iterations = '0; bi.delay = '0;
        bi.start = '0; bi.incr = '0; bi.shift = '0;
        bs.run = 1'b0; bs.period = '0; bs.iterations = '0; bs.delay = '0;
        bs.start = '0; bs.incr = '0; bs.shift = '0; bs.ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_valid", int'(bi.valid), 0);
        check("rst_addr", int'(bi.addr), 0);
        check("rst_last", int'(bi.last), 0);
        check("rst_done", int'(bi.done), 0);
        rst = 1'b0;
        @(posedge clk); #1;

        ready_mode = 0;
        seq(4, 1, 0, 'h100, 1, 0);
        seq(3, 2, 0, 0, 1, 2);
        ready_mode = 2;
        seq(4, 2, 5, 'h080, 1, 0);
        ready_mode = 0;
        seq(0, 3, 0, 'h010, 1, 0);
        seq(3, 0, 4, 'h020, 1, 0);
        seq(1, 1, 0, 'h3F0, 5, 0);

        // Restart mid-sequence with a new start address
        ready_mode = 1;
        issue_run(8, 4, 0, 'h010, 3, 1);
        repeat (7) @(posedge clk);
        #1;
        issue_run(5, 2, 0, 'h040, 1, 0);
        check("restart_valid", int'(bi.valid), 1);
        check("restart_addr", int'(bi.addr), 'h40);
        wait_done(5, 2, 0);

        // Asynchronous reset mid-sequence
        issue_run(8, 4, 2, 'h155, 2, 7);
        repeat (10) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check("arst_valid", int'(bi.valid), 0);
        check("arst_done", int'(bi.done), 0);
        check("arst_addr", int'(bi.addr), 0);
        check("arst_last", int'(bi.last), 0);
        @(posedge clk); #1;
        rst = 1'b0;
        exp_q.delete();
        @(posedge clk); #1;
        check("idle_after_rst", int'(bi.valid), 0);

        for (int r = 0; r < 25; r++) begin
            ready_mode = $urandom_range(0, 2);
            seq($urandom_range(0, 6), $urandom_range(0, 5), $urandom_range(0, 6),
                $urandom_range(0, 1023), $urandom_range(0, 1023), $urandom_range(0, 1023));
        end

        // Byte-wide elements in a 4-bit space, stepping downward through zero
        bs.run = 1'b1; bs.period = 4'd4; bs.iterations = 4'd1; bs.delay = 8'd0;
        bs.start = 4'd1; bs.incr = 4'hF; bs.shift = 4'd0;
        @(posedge clk); #1;
        bs.run = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check("small_valid", int'(bs.valid), 1);
            check("small_addr", int'(bs.addr), model_addr(4, 1, 1, -1, 0, 4, i, 0));
            check("small_last", int'(bs.last), (i == 3) ? 1 : 0);
            @(posedge clk); #1;
        end
        check("small_done", int'(bs.done), 1);
        check("small_valid_off", int'(bs.valid), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
